rh_cmd_seq: RTL and testbench

RH11 command sequencer. It accepts the CS1 GO strobe and dispatches the latched function to the selected Massbus drive. For data-transfer functions it runs the word-count / DMA handshake until completion or error. It flags non-existent drives and GO-while-busy program errors, and provides the controller-busy indication behind CS1 RDY. It sits between the RH11 register file (CS1/CS2/WC) and the drive and DMA interfaces.

---
 rtl/rh_cmd_seq_if.sv | 35 +++
 rtl/rh_cmd_seq.sv | 176 +++++++++++++++++
 tb/tb_rh_cmd_seq.sv | 304 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/rh_cmd_seq_if.sv
// RH11 command-sequencer bus: register-file, drive and DMA signals seen by rh_cmd_seq.
// The master side drives GO, function and status inputs; the slave side is the sequencer.
interface rh_cmd_seq_if;
  logic       devRESET;
  logic       rhCLR;
  logic       rhGO;
  logic [4:0] rhFUN;
  logic [2:0] rhUNIT;
  logic [15:0] rhWC;
  logic [7:0] drvPRESENT;
  logic [7:0] drvDRY;
  logic [7:0] drvERR;
  logic       dmaACK;
  logic       dmaERR;
  logic [7:0] drvGO;
  logic       dmaREQ;
  logic       rhWCINC;
  logic       rhCLRGO;
  logic       rhSETNED;
  logic       rhSETPGE;
  logic       rhDONE;
  logic       rhBUSY;

  modport master (
    output devRESET, rhCLR, rhGO, rhFUN, rhUNIT, rhWC,
    output drvPRESENT, drvDRY, drvERR, dmaACK, dmaERR,
    input  drvGO, dmaREQ, rhWCINC, rhCLRGO, rhSETNED, rhSETPGE, rhDONE, rhBUSY
  );

  modport slave (
    input  devRESET, rhCLR, rhGO, rhFUN, rhUNIT, rhWC,
    input  drvPRESENT, drvDRY, drvERR, dmaACK, dmaERR,
    output drvGO, dmaREQ, rhWCINC, rhCLRGO, rhSETNED, rhSETPGE, rhDONE, rhBUSY
  );
endinterface

// File: rtl/rh_cmd_seq.sv
// RH11 command sequencer: latches a GO command, selects the Massbus drive, issues the
// drive strobe and runs the word-count/DMA handshake for data-transfer functions.
module rh_cmd_seq #(
  parameter int unsigned NED_TIMEOUT  = 15,
  parameter logic [4:0]  XFER_FUN_MIN = 5'o24
) (
  input  logic        clk,
  input  logic        rst,
  rh_cmd_seq_if.slave bus
);

  localparam logic [7:0] NED_LAST = 8'(NED_TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_SELECT  = 3'd1,
    S_NEDWAIT = 3'd2,
    S_ISSUE   = 3'd3,
    S_XFER    = 3'd4,
    S_FINISH  = 3'd5
  } state_t;

  state_t      r_state, w_state;
  logic [4:0]  r_fun, w_fun;
  logic [2:0]  r_unit, w_unit;
  logic [15:0] r_wc, w_wc;
  logic [7:0]  r_cnt, w_cnt;
  logic [7:0]  r_drv_go, w_drv_go;
  logic        r_dma_req, w_dma_req;
  logic        r_wc_inc, w_wc_inc;
  logic        r_clr_go, w_clr_go;
  logic        r_set_ned, w_set_ned;
  logic        r_set_pge, w_set_pge;
  logic        r_done, w_done;
  logic        r_busy, w_busy;
  logic        w_srst;
  logic        w_present;
  logic        w_ready;
  logic        w_drv_err;

  assign w_srst    = bus.devRESET | bus.rhCLR;
  assign w_present = bus.drvPRESENT[r_unit];
  assign w_ready   = bus.drvDRY[r_unit];
  assign w_drv_err = bus.drvERR[r_unit];

  assign bus.drvGO    = r_drv_go;
  assign bus.dmaREQ   = r_dma_req;
  assign bus.rhWCINC  = r_wc_inc;
  assign bus.rhCLRGO  = r_clr_go;
  assign bus.rhSETNED = r_set_ned;
  assign bus.rhSETPGE = r_set_pge;
  assign bus.rhDONE   = r_done;
  assign bus.rhBUSY   = r_busy;

  // Next-state, latched-field and next-output logic; clear/device reset wins over everything.
  always_comb begin
    w_state   = r_state;
    w_fun     = r_fun;
    w_unit    = r_unit;
    w_wc      = r_wc;
    w_cnt     = r_cnt;
    w_drv_go  = 8'h00;
    w_wc_inc  = 1'b0;
    w_clr_go  = 1'b0;
    w_set_ned = 1'b0;
    w_set_pge = 1'b0;
    w_done    = 1'b0;
    if (w_srst) begin
      w_state = S_IDLE;
      w_cnt   = 8'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.rhGO) begin
            w_fun    = bus.rhFUN;
            w_unit   = bus.rhUNIT;
            w_wc     = bus.rhWC;
            w_clr_go = 1'b1;
            w_state  = S_SELECT;
          end else begin
            w_state = S_IDLE;
          end
        end
        S_SELECT: begin
          if (w_present) begin
            w_state = S_ISSUE;
          end else begin
            w_state = S_NEDWAIT;
            w_cnt   = 8'd0;
          end
        end
        S_NEDWAIT: begin
          // A drive that shows up late still gets its command.
          if (w_present) begin
            w_state = S_ISSUE;
          end else if (r_cnt == NED_LAST) begin
            w_set_ned = 1'b1;
            w_state   = S_FINISH;
          end else begin
            w_cnt = r_cnt + 8'd1;
          end
        end
        S_ISSUE: begin
          if (w_ready) begin
            w_drv_go = 8'd1 << r_unit;
            w_state  = (r_fun < XFER_FUN_MIN) ? S_FINISH : S_XFER;
          end else begin
            w_state = S_ISSUE;
          end
        end
        S_XFER: begin
          if (bus.dmaACK) begin
            w_wc     = r_wc + 16'd1;
            w_wc_inc = 1'b1;
          end else begin
            w_wc_inc = 1'b0;
          end
          // The word that completes alongside an error is still counted above.
          if ((bus.dmaACK && (r_wc == 16'hFFFF)) || bus.dmaERR || w_drv_err) begin
            w_state = S_FINISH;
          end else begin
            w_state = S_XFER;
          end
        end
        S_FINISH: begin
          w_done  = 1'b1;
          w_state = S_IDLE;
        end
        default: begin
          w_state = S_IDLE;
        end
      endcase
      if (bus.rhGO && (r_state != S_IDLE)) begin
        w_set_pge = 1'b1;
      end else begin
        w_set_pge = 1'b0;
      end
    end
    w_busy    = (w_state != S_IDLE);
    w_dma_req = (w_state == S_XFER);
  end

  // State, latched command fields and registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= S_IDLE;
      r_fun     <= 5'd0;
      r_unit    <= 3'd0;
      r_wc      <= 16'd0;
      r_cnt     <= 8'd0;
      r_drv_go  <= 8'h00;
      r_dma_req <= 1'b0;
      r_wc_inc  <= 1'b0;
      r_clr_go  <= 1'b0;
      r_set_ned <= 1'b0;
      r_set_pge <= 1'b0;
      r_done    <= 1'b0;
      r_busy    <= 1'b0;
    end else begin
      r_state   <= w_state;
      r_fun     <= w_fun;
      r_unit    <= w_unit;
      r_wc      <= w_wc;
      r_cnt     <= w_cnt;
      r_drv_go  <= w_drv_go;
      r_dma_req <= w_dma_req;
      r_wc_inc  <= w_wc_inc;
      r_clr_go  <= w_clr_go;
      r_set_ned <= w_set_ned;
      r_set_pge <= w_set_pge;
      r_done    <= w_done;
      r_busy    <= w_busy;
    end
  end

endmodule

// File: tb/tb_rh_cmd_seq.sv
// Bench for rh_cmd_seq: stimulus pushes expected output events (kind, value, cycle) into a
// queue; an independent monitor matches every observed pulse/level edge against it.
module tb_rh_cmd_seq;

  localparam int NED_T = 15;
  localparam int K_CLRGO = 0, K_DRVGO = 1, K_WCINC = 2, K_SETNED = 3, K_SETPGE = 4,
                 K_DONE = 5, K_REQUP = 6, K_REQDN = 7, K_BUSYUP = 8, K_BUSYDN = 9;

  typedef struct {
    int kind;
    int val;
    int cyc;
  } ev_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   cyc = 0;
  int   vectors = 0;
  int   miscompares = 0;
  bit   mon_en = 1'b0;
  bit   rnd_bg = 1'b0;
  ev_t  exp_q[$];

  rh_cmd_seq_if bus();

  rh_cmd_seq #(.NED_TIMEOUT(NED_T), .XFER_FUN_MIN(5'o24)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic string kname(input int k);
    case (k)
      K_CLRGO:  return "rhCLRGO";
      K_DRVGO:  return "drvGO";
      K_WCINC:  return "rhWCINC";
      K_SETNED: return "rhSETNED";
      K_SETPGE: return "rhSETPGE";
      K_DONE:   return "rhDONE";
      K_REQUP:  return "dmaREQ_rise";
      K_REQDN:  return "dmaREQ_fall";
      K_BUSYUP: return "rhBUSY_rise";
      K_BUSYDN: return "rhBUSY_fall";
      default:  return "unknown";
    endcase
  endfunction

  task automatic push(input int k, input int v, input int c);
    ev_t e;
    e.kind = k;
    e.val  = v;
    e.cyc  = c;
    exp_q.push_back(e);
  endtask

  task automatic observe(input int k, input int v);
    int idx;
    idx = -1;
    for (int i = 0; i < exp_q.size(); i++)
      if (idx < 0 && exp_q[i].kind == k && exp_q[i].cyc == cyc) idx = i;
    vectors++;
    if (idx < 0) begin
      miscompares++;
      $display("FAIL %s unexpected at cycle %0d: got value %0h, required no event", kname(k), cyc, v);
    end else begin
      if (exp_q[idx].val != v) begin
        miscompares++;
        $display("FAIL %s at cycle %0d: got %0h, required %0h", kname(k), cyc, v, exp_q[idx].val);
      end
      exp_q.delete(idx);
    end
  endtask

  task automatic flush_missing();
    for (int i = exp_q.size() - 1; i >= 0; i--) begin
      if (exp_q[i].cyc <= cyc) begin
        vectors++;
        miscompares++;
        $display("FAIL %s missing at cycle %0d: got no event, required value %0h", kname(exp_q[i].kind),
                 exp_q[i].cyc, exp_q[i].val);
        exp_q.delete(i);
      end
    end
  endtask

  task automatic check_idle(input string name);
    logic [14:0] outs;
    outs = {bus.drvGO, bus.dmaREQ, bus.rhWCINC, bus.rhCLRGO, bus.rhSETNED, bus.rhSETPGE, bus.rhDONE, bus.rhBUSY};
    vectors++;
    if (outs !== 15'h0000) begin
      miscompares++;
      $display("FAIL %s: outputs got %04h, required 0000", name, outs);
    end
  endtask

  // Monitor: every output pulse and every dmaREQ/rhBUSY edge must match an expected event.
  initial begin : monitor
    bit p_req, p_busy;
    p_req = 1'b0;
    p_busy = 1'b0;
    forever begin
      @(negedge clk);
      if (mon_en) begin
        if (bus.rhCLRGO)           observe(K_CLRGO, 0);
        if (bus.drvGO != 8'h00)    observe(K_DRVGO, int'(bus.drvGO));
        if (bus.rhWCINC)           observe(K_WCINC, 0);
        if (bus.rhSETNED)          observe(K_SETNED, 0);
        if (bus.rhSETPGE)          observe(K_SETPGE, 0);
        if (bus.rhDONE)            observe(K_DONE, 0);
        if (bus.dmaREQ != p_req)   observe(bus.dmaREQ ? K_REQUP : K_REQDN, 0);
        if (bus.rhBUSY != p_busy)  observe(bus.rhBUSY ? K_BUSYUP : K_BUSYDN, 0);
        flush_missing();
      end
      p_req  = bus.dmaREQ;
      p_busy = bus.rhBUSY;
    end
  end

  task automatic wait_cyc(input int t);
    while (cyc < t) @(negedge clk);
  endtask

  // One command from GO to completion; returns at the negedge of the cycle before rhDONE
  // (or once idle after an abort), so a following call exercises back-to-back GO.
  task automatic run_cmd(input logic [4:0] fun, input logic [2:0] unit, input logic [15:0] wc,
                         input bit present, input int dry_delay, input int ack_pct,
                         input int err_at, input bit err_dma, input bit err_ack,
                         input int pge_at, input int clr_at, input bit rst_issue);
    int g, t_go, words, n, k, c;
    bit ack, err;
    logic [7:0] ub, bg;
    ub = 8'h01 << unit;
    bg = rnd_bg ? 8'($urandom) : 8'h00;
    @(negedge clk);
    bus.drvPRESENT = present ? (bg | ub) : (bg & ~ub);
    bus.drvDRY     = (dry_delay == 0) ? (bg | ub) : (bg & ~ub);
    bus.drvERR     = rnd_bg ? (8'($urandom) & ~ub) : 8'h00;
    bus.rhGO   = 1'b1;
    bus.rhFUN  = fun;
    bus.rhUNIT = unit;
    bus.rhWC   = wc;
    g = cyc + 1;
    push(K_CLRGO, 0, g);
    push(K_BUSYUP, 0, g);
    @(negedge clk);
    bus.rhGO   = 1'b0;
    bus.rhFUN  = 5'($urandom);
    bus.rhUNIT = 3'($urandom);
    bus.rhWC   = 16'($urandom);
    if (!present) begin
      push(K_SETNED, 0, g + NED_T + 1);
      push(K_DONE, 0, g + NED_T + 2);
      push(K_BUSYDN, 0, g + NED_T + 2);
      wait_cyc(g + NED_T + 1);
      return;
    end
    if (rst_issue) begin
      wait_cyc(g + 1);
      push(K_BUSYDN, 0, g + 2);
      #2 rst = 1'b0;
      @(negedge clk);
      check_idle("async_rst_in_issue");
      #2 rst = 1'b1;
      @(negedge clk);
      return;
    end
    t_go = g + 2 + dry_delay;
    push(K_DRVGO, int'(ub), t_go);
    if (dry_delay > 0) begin
      wait_cyc(g + 1 + dry_delay);
      bus.drvDRY = bus.drvDRY | ub;
    end
    if (int'(fun) < 20) begin
      push(K_DONE, 0, t_go + 1);
      push(K_BUSYDN, 0, t_go + 1);
      wait_cyc(t_go);
      return;
    end
    push(K_REQUP, 0, t_go);
    words = (wc == 16'h0000) ? 65536 : 65536 - int'(wc);
    wait_cyc(t_go);
    n = 0;
    k = 0;
    forever begin
      c = cyc;
      ack = ($urandom_range(0, 99) < ack_pct);
      if (k == clr_at) begin
        if ($urandom_range(0, 1) == 0) bus.rhCLR = 1'b1;
        else bus.devRESET = 1'b1;
        bus.dmaACK = ack;
        push(K_REQDN, 0, c + 1);
        push(K_BUSYDN, 0, c + 1);
        @(negedge clk);
        bus.rhCLR = 1'b0;
        bus.devRESET = 1'b0;
        bus.dmaACK = 1'b0;
        return;
      end
      err = (err_at >= 0) && (n == err_at);
      if (err) begin
        ack = err_ack;
        if (err_dma) bus.dmaERR = 1'b1;
        else bus.drvERR = bus.drvERR | ub;
      end
      if (k == pge_at) begin
        bus.rhGO   = 1'b1;
        bus.rhFUN  = 5'($urandom);
        bus.rhUNIT = 3'($urandom);
        bus.rhWC   = 16'($urandom);
        push(K_SETPGE, 0, c + 1);
      end
      bus.dmaACK = ack;
      if (ack) begin
        n++;
        push(K_WCINC, 0, c + 1);
      end
      if (err || (ack && n == words)) begin
        push(K_REQDN, 0, c + 1);
        push(K_DONE, 0, c + 2);
        push(K_BUSYDN, 0, c + 2);
        @(negedge clk);
        bus.dmaACK = 1'b0;
        bus.dmaERR = 1'b0;
        bus.rhGO   = 1'b0;
        bus.drvERR = bus.drvERR & ~ub;
        return;
      end
      @(negedge clk);
      bus.dmaACK = 1'b0;
      bus.rhGO   = 1'b0;
      k++;
      if (k > 4000) begin
        $display("FAIL stimulus_runaway: got %0d transfer cycles, required at most 4000", k);
        $fatal(1, "stimulus runaway");
      end
    end
  endtask

  initial begin : stimulus
    logic [4:0]  fun;
    logic [15:0] wc;
    int words, lim, err_at, pge_at, clr_at;
    bus.devRESET = 1'b0;
    bus.rhCLR = 1'b0;
    bus.rhGO = 1'b0;
    bus.rhFUN = 5'd0;
    bus.rhUNIT = 3'd0;
    bus.rhWC = 16'd0;
    bus.drvPRESENT = 8'h00;
    bus.drvDRY = 8'h00;
    bus.drvERR = 8'h00;
    bus.dmaACK = 1'b0;
    bus.dmaERR = 1'b0;
    repeat (3) @(negedge clk);
    check_idle("reset");
    #2 rst = 1'b1;
    @(negedge clk);
    mon_en = 1'b1;

    run_cmd(5'o03, 3'd2, 16'h0000, 1'b1, 0, 50, -1, 1'b0, 1'b0, -1, -1, 1'b0);
    run_cmd(5'o30, 3'd1, 16'hFFFD, 1'b1, 0, 100, -1, 1'b0, 1'b0, -1, -1, 1'b0);
    // Stray ACKs after the transfer has ended must not bump the word count.
    bus.dmaACK = 1'b1;
    repeat (2) @(negedge clk);
    bus.dmaACK = 1'b0;
    run_cmd(5'o03, 3'd5, 16'h0000, 1'b0, 0, 50, -1, 1'b0, 1'b0, -1, -1, 1'b0);
    run_cmd(5'o31, 3'd3, 16'hFFFA, 1'b1, 1, 70, -1, 1'b0, 1'b0, 1, -1, 1'b0);
    run_cmd(5'o30, 3'd4, 16'hFFF0, 1'b1, 0, 50, 0, 1'b1, 1'b1, -1, -1, 1'b0);
    run_cmd(5'o26, 3'd6, 16'hFFF8, 1'b1, 2, 60, 3, 1'b0, 1'b0, -1, -1, 1'b0);
    run_cmd(5'o24, 3'd0, 16'h0000, 1'b1, 0, 100, 5, 1'b1, 1'b0, -1, -1, 1'b0);
    run_cmd(5'o30, 3'd7, 16'hFFF0, 1'b1, 0, 80, -1, 1'b0, 1'b0, -1, 2, 1'b0);
    run_cmd(5'o30, 3'd2, 16'hFFFE, 1'b1, 3, 50, -1, 1'b0, 1'b0, -1, -1, 1'b1);
    run_cmd(5'o03, 3'd2, 16'h0000, 1'b1, 0, 50, -1, 1'b0, 1'b0, -1, -1, 1'b0);
    run_cmd(5'o11, 3'd6, 16'h1234, 1'b1, 2, 50, -1, 1'b0, 1'b0, -1, -1, 1'b0);

    rnd_bg = 1'b1;
    for (int it = 0; it < 60; it++) begin
      fun = 5'($urandom);
      wc = ($urandom_range(0, 9) == 0) ? 16'h0000 : 16'(32'h0000FFFF - $urandom_range(0, 6));
      words = (wc == 16'h0000) ? 65536 : 65536 - int'(wc);
      lim = (words - 1 < 6) ? words - 1 : 6;
      err_at = (wc == 16'h0000 || $urandom_range(0, 3) == 0) ? int'($urandom_range(0, lim)) : -1;
      pge_at = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, 4)) : -1;
      clr_at = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 4)) : -1;
      run_cmd(fun, 3'($urandom), wc, ($urandom_range(0, 5) != 0), int'($urandom_range(0, 3)),
              int'($urandom_range(30, 100)), err_at, 1'($urandom), 1'($urandom), pge_at, clr_at, 1'b0);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    repeat (6) @(negedge clk);
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL pending_events: got %0d unmatched expectations, required 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
